// File: rtl/gpio_dbs_pkg.sv
// rtl/gpio_dbs_pkg.sv - shared sizing helpers and event type for the GPIO debounce scheduler
package gpio_dbs_pkg;

    localparam int MAX_CHW = 5;

    typedef struct packed {
        logic [MAX_CHW-1:0] chan;
        logic               level;
    } gpio_evt_t;

    function automatic int calc_prescale(input int clock_freq, input int sample_freq);
        return clock_freq / sample_freq;
    endfunction

    function automatic int calc_pre_w(input int clock_freq, input int sample_freq);
        return $clog2(calc_prescale(clock_freq, sample_freq));
    endfunction

    function automatic int calc_cnt_w(input int debounce_samples);
        return $clog2(debounce_samples + 1);
    endfunction

    function automatic int calc_chw(input int num_inputs);
        return $clog2(num_inputs);
    endfunction

endpackage

// File: rtl/gpio_dbs_rr_arbiter.sv
// rtl/gpio_dbs_rr_arbiter.sv - combinational round-robin picker: first pending channel after the pointer
module gpio_dbs_rr_arbiter #(
    parameter int N   = 8,
    parameter int CHW = 3
) (
    input  logic [N-1:0]   pend_i,
    input  logic [CHW-1:0] ptr_i,
    output logic [CHW-1:0] grant_o,
    output logic           any_o
);

    int idx;

    // Scan from the farthest slot back to the nearest so the nearest pending one wins.
    always_comb begin
        grant_o = '0;
        any_o   = |pend_i;
        idx     = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr_i) + k) % N;
            if (pend_i[idx]) begin
                grant_o = CHW'(idx);
            end
        end
    end

endmodule

// File: rtl/gpio_debounce_scheduler.sv
// rtl/gpio_debounce_scheduler.sv - debounced GPIO levels turned into round-robin events; GPIO_SYNC2_EN adds 2-flop input synchronizers
module gpio_debounce_scheduler
    import gpio_dbs_pkg::*;
#(
    parameter int                    NUM_INPUTS       = 8,
    parameter int                    CLOCK_FREQ       = 100000000,
    parameter int                    SAMPLE_FREQ      = 10000,
    parameter int                    DEBOUNCE_SAMPLES = 10,
    parameter logic [NUM_INPUTS-1:0] INITIAL_VALUE    = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_INPUTS-1:0]         gpio_i,
    output logic [NUM_INPUTS-1:0]         level_o,
    output logic                          evt_valid_o,
    output logic [$clog2(NUM_INPUTS)-1:0] evt_chan_o,
    output logic                          evt_level_o,
    input  logic                          evt_ready_i,
    output logic [NUM_INPUTS-1:0]         overflow_o,
    input  logic                          ovf_clr_i
);

    localparam int PRESCALE = calc_prescale(CLOCK_FREQ, SAMPLE_FREQ);
    localparam int PW       = calc_pre_w(CLOCK_FREQ, SAMPLE_FREQ);
    localparam int CW       = calc_cnt_w(DEBOUNCE_SAMPLES);
    localparam int CHW      = calc_chw(NUM_INPUTS);

    logic [PW-1:0]         pre_q, pre_d;
    logic                  tick;
    logic [NUM_INPUTS-1:0] samp;
    logic [NUM_INPUTS-1:0] level_q, level_d;
    logic [NUM_INPUTS-1:0] pend_q, pend_d;
    logic [NUM_INPUTS-1:0] pend_lvl_q, pend_lvl_d;
    logic [NUM_INPUTS-1:0] ovf_q, ovf_d;
    logic [NUM_INPUTS-1:0] flip;
    logic                  evt_valid_q, evt_valid_d;
    logic [CHW-1:0]        evt_chan_q, evt_chan_d;
    logic                  evt_level_q, evt_level_d;
    logic [CHW-1:0]        ptr_q, ptr_d;
    logic [CHW-1:0]        grant;
    logic                  any_pend;
    logic                  load;

`ifdef GPIO_SYNC2_EN
    logic [NUM_INPUTS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= INITIAL_VALUE;
            sync2_q <= INITIAL_VALUE;
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
        end
    end

    assign samp = sync2_q;
`else
    assign samp = gpio_i;
`endif

    assign tick = (pre_q == PW'(PRESCALE - 1));

    always_comb begin
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

    gpio_dbs_rr_arbiter #(
        .N   (NUM_INPUTS),
        .CHW (CHW)
    ) u_arb (
        .pend_i  (pend_q),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .any_o   (any_pend)
    );

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
        logic [CW-1:0] cnt_q, cnt_d;
        logic          flip_c;
        logic          taken;
        logic          pend_c, lvl_c, ovf_c;

        assign taken = load && (grant == CHW'(i));

        always_comb begin
            cnt_d  = cnt_q;
            flip_c = 1'b0;
            if (tick) begin
                if (samp[i] == level_q[i]) begin
                    cnt_d = '0;
                end else if (cnt_q + CW'(1) == CW'(DEBOUNCE_SAMPLES)) begin
                    cnt_d  = '0;
                    flip_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        // A flip on a channel being granted this cycle is a fresh event, not a lost one.
        always_comb begin
            pend_c = pend_q[i];
            lvl_c  = pend_lvl_q[i];
            ovf_c  = ovf_q[i];
            if (ovf_clr_i) ovf_c = 1'b0;
            if (taken) pend_c = 1'b0;
            if (flip_c) begin
                if (pend_q[i] && !taken) ovf_c = 1'b1;
                pend_c = 1'b1;
                lvl_c  = ~level_q[i];
            end
        end

        assign flip[i]       = flip_c;
        assign level_d[i]    = level_q[i] ^ flip_c;
        assign pend_d[i]     = pend_c;
        assign pend_lvl_d[i] = lvl_c;
        assign ovf_d[i]      = ovf_c;

        always_ff @(posedge clk) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
        end
    end

    always_comb begin
        load        = (!evt_valid_q || evt_ready_i) && any_pend;
        evt_valid_d = evt_valid_q;
        evt_chan_d  = evt_chan_q;
        evt_level_d = evt_level_q;
        ptr_d       = ptr_q;
        if (load) begin
            evt_valid_d = 1'b1;
            evt_chan_d  = grant;
            evt_level_d = pend_lvl_q[grant];
            ptr_d       = grant;
        end else if (evt_ready_i) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q       <= '0;
            level_q     <= INITIAL_VALUE;
            pend_q      <= '0;
            pend_lvl_q  <= '0;
            ovf_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_chan_q  <= '0;
            evt_level_q <= 1'b0;
            ptr_q       <= CHW'(NUM_INPUTS - 1);
        end else begin
            pre_q       <= pre_d;
            level_q     <= level_d;
            pend_q      <= pend_d;
            pend_lvl_q  <= pend_lvl_d;
            ovf_q       <= ovf_d;
            evt_valid_q <= evt_valid_d;
            evt_chan_q  <= evt_chan_d;
            evt_level_q <= evt_level_d;
            ptr_q       <= ptr_d;
        end
    end

    assign level_o     = level_q;
    assign evt_valid_o = evt_valid_q;
    assign evt_chan_o  = evt_chan_q;
    assign evt_level_o = evt_level_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_gpio_debounce_scheduler.sv
// tb/tb_gpio_debounce_scheduler.sv - directed self-checking bench for gpio_debounce_scheduler
module tb_gpio_debounce_scheduler;
    import gpio_dbs_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] gpio_i = 4'b0;
    logic [3:0] level_o;
    logic       evt_valid_o;
    logic [1:0] evt_chan_o;
    logic       evt_level_o;
    logic       evt_ready_i = 1'b1;
    logic [3:0] overflow_o;
    logic       ovf_clr_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int seen = 0;
    gpio_evt_t exp_e;

    gpio_debounce_scheduler #(
        .NUM_INPUTS       (4),
        .CLOCK_FREQ       (100),
        .SAMPLE_FREQ      (10),
        .DEBOUNCE_SAMPLES (3),
        .INITIAL_VALUE    (4'b0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .gpio_i      (gpio_i),
        .level_o     (level_o),
        .evt_valid_o (evt_valid_o),
        .evt_chan_o  (evt_chan_o),
        .evt_level_o (evt_level_o),
        .evt_ready_i (evt_ready_i),
        .overflow_o  (overflow_o),
        .ovf_clr_i   (ovf_clr_i)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        n++;
        if (evt_valid_o) seen++;
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    // Edge n (n > 0, n % 10 == 0) after do_reset is a sample tick.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        seen = 0;
    endtask

    task automatic test_reset();
        gpio_i = 4'b0; evt_ready_i = 1'b1; ovf_clr_i = 1'b0;
        do_reset();
        checks++;
        if ({level_o, evt_valid_o, evt_chan_o, evt_level_o, overflow_o} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state: got lvl=%b v=%b ch=%0d l=%b ovf=%b, want all zero",
                     level_o, evt_valid_o, evt_chan_o, evt_level_o, overflow_o);
        end
    endtask

    task automatic test_clean_press();
        do_reset();
        gpio_i = 4'b0100;
        run_to(29);
        checks++;
        if (level_o !== 4'b0000 || seen !== 0) begin
            errors++;
            $display("FAIL press_before_3rd_tick: lvl=%b events=%0d, want 0000 and 0", level_o, seen);
        end
        run_to(30);
        checks++;
        if (level_o !== 4'b0100 || evt_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL press_level: lvl=%b v=%b, want 0100 v=0", level_o, evt_valid_o);
        end
        run_to(31);
        exp_e.chan = 5'd2; exp_e.level = 1'b1;
        checks++;
        if (evt_valid_o !== 1'b1 || evt_chan_o !== exp_e.chan[1:0] || evt_level_o !== exp_e.level) begin
            errors++;
            $display("FAIL press_event: v=%b ch=%0d l=%b, want v=1 ch=2 l=1", evt_valid_o, evt_chan_o, evt_level_o);
        end
        run_to(45);
        checks++;
        if (seen !== 1) begin
            errors++;
            $display("FAIL press_single_cycle: valid cycles=%0d, want 1", seen);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        gpio_i = 4'b0001;
        run_to(20);
        gpio_i = 4'b0000;
        run_to(30);
        checks++;
        if (level_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_level_during: lvl0=%b, want 0", level_o[0]);
        end
        gpio_i = 4'b0001;
        run_to(59);
        checks++;
        if (level_o[0] !== 1'b0 || seen !== 0) begin
            errors++;
            $display("FAIL glitch_no_early_event: lvl0=%b events=%0d, want 0 and 0", level_o[0], seen);
        end
        run_to(61);
        checks++;
        if (level_o[0] !== 1'b1 || evt_valid_o !== 1'b1 || evt_chan_o !== 2'd0 || evt_level_o !== 1'b1) begin
            errors++;
            $display("FAIL glitch_event: lvl0=%b v=%b ch=%0d l=%b, want 1 1 0 1",
                     level_o[0], evt_valid_o, evt_chan_o, evt_level_o);
        end
        gpio_i = 4'b0000;
    endtask

    task automatic test_back_to_back();
        do_reset();
        gpio_i = 4'b1010;
        run_to(31);
        checks++;
        if (evt_valid_o !== 1'b1 || evt_chan_o !== 2'd1 || evt_level_o !== 1'b1) begin
            errors++;
            $display("FAIL pair1_first: v=%b ch=%0d l=%b, want 1 1 1", evt_valid_o, evt_chan_o, evt_level_o);
        end
        run_to(32);
        checks++;
        if (evt_valid_o !== 1'b1 || evt_chan_o !== 2'd3 || evt_level_o !== 1'b1) begin
            errors++;
            $display("FAIL pair1_second: v=%b ch=%0d l=%b, want 1 3 1", evt_valid_o, evt_chan_o, evt_level_o);
        end
        run_to(33);
        checks++;
        if (evt_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL pair1_drain: v=%b, want 0", evt_valid_o);
        end
        gpio_i = 4'b1000;
        run_to(61);
        checks++;
        if (evt_valid_o !== 1'b1 || evt_chan_o !== 2'd1 || evt_level_o !== 1'b0) begin
            errors++;
            $display("FAIL single_ch1: v=%b ch=%0d l=%b, want 1 1 0", evt_valid_o, evt_chan_o, evt_level_o);
        end
        gpio_i = 4'b0001;
        run_to(91);
        checks++;
        if (evt_valid_o !== 1'b1 || evt_chan_o !== 2'd3 || evt_level_o !== 1'b0) begin
            errors++;
            $display("FAIL pair2_first: v=%b ch=%0d l=%b, want 1 3 0", evt_valid_o, evt_chan_o, evt_level_o);
        end
        run_to(92);
        checks++;
        if (evt_valid_o !== 1'b1 || evt_chan_o !== 2'd0 || evt_level_o !== 1'b1) begin
            errors++;
            $display("FAIL pair2_second: v=%b ch=%0d l=%b, want 1 0 1", evt_valid_o, evt_chan_o, evt_level_o);
        end
        run_to(93);
        checks++;
        if (evt_valid_o !== 1'b0 || level_o !== 4'b0001) begin
            errors++;
            $display("FAIL pair2_drain: v=%b lvl=%b, want 0 0001", evt_valid_o, level_o);
        end
        gpio_i = 4'b0000;
    endtask

    task automatic test_backpressure();
        evt_ready_i = 1'b0;
        do_reset();
        gpio_i = 4'b0100;
        run_to(10);
        gpio_i = 4'b0110;
        run_to(40);
        gpio_i = 4'b0100;
        run_to(69);
        checks++;
        if (overflow_o !== 4'b0000 || evt_valid_o !== 1'b1 || evt_chan_o !== 2'd2 || evt_level_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold_early: ovf=%b v=%b ch=%0d l=%b, want 0000 1 2 1",
                     overflow_o, evt_valid_o, evt_chan_o, evt_level_o);
        end
        run_to(75);
        checks++;
        if (overflow_o !== 4'b0010 || evt_valid_o !== 1'b1 || evt_chan_o !== 2'd2 || evt_level_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_overflow_hold: ovf=%b v=%b ch=%0d l=%b, want 0010 1 2 1",
                     overflow_o, evt_valid_o, evt_chan_o, evt_level_o);
        end
        evt_ready_i = 1'b1;
        run_to(76);
        checks++;
        if (evt_valid_o !== 1'b1 || evt_chan_o !== 2'd1 || evt_level_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_event: v=%b ch=%0d l=%b, want 1 1 0", evt_valid_o, evt_chan_o, evt_level_o);
        end
        run_to(77);
        checks++;
        if (evt_valid_o !== 1'b0 || overflow_o !== 4'b0010) begin
            errors++;
            $display("FAIL bp_drain: v=%b ovf=%b, want 0 0010", evt_valid_o, overflow_o);
        end
        ovf_clr_i = 1'b1;
        run_to(78);
        ovf_clr_i = 1'b0;
        checks++;
        if (overflow_o !== 4'b0000) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b, want 0000", overflow_o);
        end
        gpio_i = 4'b0000;
    endtask

    task automatic test_reset_mid();
        evt_ready_i = 1'b0;
        do_reset();
        gpio_i = 4'b0110;
        run_to(31);
        checks++;
        if (evt_valid_o !== 1'b1 || evt_chan_o !== 2'd1) begin
            errors++;
            $display("FAIL rstmid_setup: v=%b ch=%0d, want 1 1", evt_valid_o, evt_chan_o);
        end
        rst = 1'b1;
        gpio_i = 4'b0000;
        @(posedge clk);
        #1;
        checks++;
        if ({level_o, evt_valid_o, evt_chan_o, evt_level_o, overflow_o} !== 12'h000) begin
            errors++;
            $display("FAIL rstmid_state: lvl=%b v=%b ch=%0d l=%b ovf=%b, want all zero",
                     level_o, evt_valid_o, evt_chan_o, evt_level_o, overflow_o);
        end
        rst = 1'b0;
        evt_ready_i = 1'b1;
        n = 0;
        seen = 0;
        run_to(25);
        checks++;
        if (seen !== 0 || level_o !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_discard: events=%0d lvl=%b, want 0 0000", seen, level_o);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
